// File: rtl/cymometer_pkg.sv
// Shared types and constants for the cymometer gate generator and fx_calc.
// No logic; both blocks import GATE_CYCLES_DEF so the gate width is one value.
package cymometer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DIV,
        DONE
    } fx_state_e;

    localparam longint unsigned CLK_FS_FREQ_DEF = 64'd50_000_000;
    localparam longint unsigned GATE_CYCLES_DEF = 64'd5;

    // Constant numerator of fx = f_ref * Nx / Ns.
    function automatic logic [63:0] fx_num(input longint unsigned f_ref,
                                           input longint unsigned n_gate);
        return 64'(f_ref * n_gate);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle (W >= 2).
// Latency: done pulses exactly W cycles after start; no backpressure, start is accepted while idle.
// quo is held after done until the next start.
module seq_divider #(
    parameter int W = 64
) (
    input  logic         clk_fs,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic [W-1:0] quo,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;
    logic          run;
    logic          done_r;

    // One restoring step: shift the next numerator bit into the remainder.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r_in,
                                                input logic [W-1:0] q_in,
                                                input logic [W-1:0] d_in);
        logic [W:0] sh;
        logic [W:0] r_out;
        logic       qb;
        sh    = {r_in, q_in[W-1]};
        r_out = sh;
        qb    = 1'b0;
        if (sh >= {1'b0, d_in}) begin
            r_out = sh - {1'b0, d_in};
            qb    = 1'b1;
        end
        return {r_out[W-1:0], q_in[W-2:0], qb};
    endfunction

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            q      <= '0;
            d      <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                {rem, q} <= div_step('0, num, den);
                d        <= den;
                cnt      <= CW'(W - 1);
                run      <= 1'b1;
            end else if (run) begin
                {rem, q} <= div_step(rem, q, d);
                cnt      <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run    <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign quo  = q;
    assign busy = run | done_r;
    assign done = done_r;

endmodule

// File: rtl/fx_calc.sv
// Measures gate_fs high time in clk_fs cycles and computes fx = CLK_FS_FREQ*GATE_CYCLES/Ns.
// Latency: freq_valid pulses NUM_W+1 cycles after fall is detected; no backpressure, gates during DIV/DONE are skipped.
// FX_CALC_ROUND_EN: round-to-nearest quotient instead of floor.
module fx_calc
    import cymometer_pkg::*;
#(
    parameter longint unsigned CLK_FS_FREQ = CLK_FS_FREQ_DEF,
    parameter longint unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int              CNT_W       = 32,
    parameter int              FREQ_W      = 32,
    parameter int              NUM_W       = 64
) (
    input  logic              clk_fs,
    input  logic              rst_n,
    input  logic              gate_fs,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              err,
    output logic              busy
);

    localparam logic [NUM_W-1:0] NUM      = NUM_W'(fx_num(CLK_FS_FREQ, GATE_CYCLES));
    localparam logic [NUM_W-1:0] FREQ_MAX = (NUM_W'(1) << FREQ_W) - NUM_W'(1);

    fx_state_e        state;
    fx_state_e        state_nxt;
    logic             gate_d;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             div_start;
    logic [NUM_W-1:0] div_num;
    logic [NUM_W-1:0] div_den;
    logic [NUM_W-1:0] div_quo;
    logic             div_busy;
    logic             div_done;
    logic             quo_ovf;

    assign rise = gate_fs & ~gate_d;
    assign fall = ~gate_fs & gate_d;

`ifdef FX_CALC_ROUND_EN
    assign div_num = NUM + NUM_W'(cnt >> 1);
`else
    assign div_num = NUM;
`endif
    // The divider latches den on start, so it doubles as the ns register.
    assign div_den = NUM_W'(cnt);
    assign quo_ovf = div_quo > FREQ_MAX;

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE:  if (rise) state_nxt = COUNT;
            COUNT: begin
                if (fall) begin
                    state_nxt = DIV;
                    div_start = 1'b1;
                end
            end
            DIV:   if (div_done) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gate_d <= 1'b0;
            cnt    <= '0;
            ovf    <= 1'b0;
            freq   <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            gate_d <= gate_fs;
            if (state == IDLE && rise) begin
                cnt <= CNT_W'(1);
                ovf <= 1'b0;
            end else if (state == COUNT && gate_fs) begin
                if (cnt == '1) ovf <= 1'b1;
                else           cnt <= cnt + 1'b1;
            end
            if (state == DIV && div_done) begin
                freq <= quo_ovf ? '1 : div_quo[FREQ_W-1:0];
                err  <= ovf | quo_ovf;
            end
        end
    end

    seq_divider #(
        .W (NUM_W)
    ) u_div (
        .clk_fs (clk_fs),
        .rst_n  (rst_n),
        .start  (div_start),
        .num    (div_num),
        .den    (div_den),
        .quo    (div_quo),
        .busy   (div_busy),
        .done   (div_done)
    );

    assign freq_valid = (state == DONE);
    assign busy       = (state == COUNT) | (state == DONE) | div_busy;

endmodule

// File: tb/tb_fx_calc.sv
// Directed bench for fx_calc: default, 8-bit counter and 16-bit result instances.
`timescale 1ns/1ps
module tb_fx_calc;

    logic        clk_fs = 1'b0;
    logic        rst_n;
    logic        gate_fs, gate_sat, gate_w16;
    logic [31:0] freq, sat_freq;
    logic [15:0] w16_freq;
    logic        freq_valid, err, busy;
    logic        sat_valid, sat_err, sat_busy;
    logic        w16_valid, w16_err, w16_busy;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;

    typedef struct {
        longint freq;
        logic   err;
        longint cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_fs = ~clk_fs;
    always @(posedge clk_fs) cyc++;

    fx_calc u_dut (
        .clk_fs(clk_fs), .rst_n(rst_n), .gate_fs(gate_fs),
        .freq(freq), .freq_valid(freq_valid), .err(err), .busy(busy)
    );

    fx_calc #(.CNT_W(8)) u_sat (
        .clk_fs(clk_fs), .rst_n(rst_n), .gate_fs(gate_sat),
        .freq(sat_freq), .freq_valid(sat_valid), .err(sat_err), .busy(sat_busy)
    );

    fx_calc #(.FREQ_W(16)) u_w16 (
        .clk_fs(clk_fs), .rst_n(rst_n), .gate_fs(gate_w16),
        .freq(w16_freq), .freq_valid(w16_valid), .err(w16_err), .busy(w16_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: 50 MHz * 5 gate cycles over ns, optionally rounded.
    function automatic longint model(input longint ns);
        longint num;
        num = 64'd250_000_000;
`ifdef FX_CALC_ROUND_EN
        num = num + ns / 2;
`endif
        return num / ns;
    endfunction

    always @(negedge clk_fs) begin
        if (rst_n === 1'b1 && freq_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed freq=%0d expected no strobe", freq);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_freq", 64'(freq), 64'(e.freq));
                check("sb_err", 64'(err), 64'(e.err));
                check("sb_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic pulse(input int n, input bit expect_result);
        @(negedge clk_fs) gate_fs = 1'b1;
        repeat (n) @(negedge clk_fs);
        gate_fs = 1'b0;
        if (expect_result) begin
            exp_t e;
            e.freq = model(n);
            e.err  = 1'b0;
            e.cyc  = cyc + 65;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk_fs);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        gate_fs  = 1'b0;
        gate_sat = 1'b0;
        gate_w16 = 1'b0;
        repeat (3) @(negedge clk_fs);
        check("rst_freq", 64'(freq), 64'd0);
        check("rst_valid", 64'(freq_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_fs);

        pulse(250, 1'b1);
        check("busy_in_div", 64'(busy), 64'd1);
        drain("drain_250");
        repeat (20) @(negedge clk_fs);
        check("hold_freq", 64'(freq), 64'd1_000_000);
        check("hold_valid", 64'(freq_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        pulse(7, 1'b1);
        drain("drain_7");
        repeat (5) @(negedge clk_fs);
        pulse(1, 1'b1);
        drain("drain_1");
        repeat (5) @(negedge clk_fs);

        // Second gate rises 10 cycles after the first fall, inside DIV.
        pulse(250, 1'b1);
        repeat (10) @(negedge clk_fs);
        pulse(250, 1'b0);
        drain("drain_b2b_first");
        repeat (20) @(negedge clk_fs);
        pulse(125, 1'b1);
        drain("drain_b2b_third");
        repeat (5) @(negedge clk_fs);

        @(negedge clk_fs) gate_sat = 1'b1;
        repeat (300) @(negedge clk_fs);
        gate_sat = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_fs);
            if (sat_valid) break;
        end
        check("sat_valid", 64'(sat_valid), 64'd1);
        check("sat_freq", 64'(sat_freq), 64'd980_392);
        check("sat_err", 64'(sat_err), 64'd1);

        @(negedge clk_fs) gate_w16 = 1'b1;
        repeat (250) @(negedge clk_fs);
        gate_w16 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_fs);
            if (w16_valid) break;
        end
        check("w16_valid", 64'(w16_valid), 64'd1);
        check("w16_freq", 64'(w16_freq), 64'hFFFF);
        check("w16_err", 64'(w16_err), 64'd1);

        // Reset lands mid-DIV; the partial result must vanish.
        pulse(100, 1'b0);
        repeat (20) @(negedge clk_fs);
        check("mid_div_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk_fs);
        check("mid_rst_freq", 64'(freq), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk_fs);
        check("post_rst_freq", 64'(freq), 64'd0);
        pulse(500, 1'b1);
        drain("drain_500");
        repeat (5) @(negedge clk_fs);
        check("final_freq", 64'(freq), 64'(model(500)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_calc.md
Name: fx_calc

Overview:
Downstream stage of the gate generator in the cymometer. It measures how long the synchronized gate (gate_fs) stays high, counted in reference-clock cycles (Ns). It then computes the measured frequency as fx = CLK_FS_FREQ * GATE_CYCLES / Ns using a sequential restoring divider. The result goes to the display/UART path as a held value plus a one-cycle valid strobe.

Parameters:
CLK_FS_FREQ, 50_000_000, reference clock frequency in Hz
GATE_CYCLES, 5, number of clk_fx periods in one gate-high window (Nx); must match the gate generator
CNT_W, 32, width of the Ns counter
FREQ_W, 32, width of the frequency result
NUM_W, 64, width of the constant numerator CLK_FS_FREQ*GATE_CYCLES and the divider iteration count

Ports:
clk_fs  in  1  reference clock; the only clock in this block
rst_n  in  1  asynchronous active-low reset
gate_fs  in  1  gate already synchronized to clk_fs
freq  out  FREQ_W  last computed frequency in Hz; held between results
freq_valid  out  1  one-cycle strobe when freq updates
err  out  1  qualifies the current freq; valid when freq_valid=1, held until the next result
busy  out  1  high in COUNT, DIV and DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; freq=0, freq_valid=0, err=0, busy=0; gate_d=0, cnt=0.
- Edge detection: gate_d is gate_fs registered once.
  - rise = gate_fs & ~gate_d
  - fall = ~gate_fs & gate_d
- IDLE: on rise, go to COUNT with cnt=1.
- COUNT: cnt increments each cycle gate_fs=1. cnt saturates at all-ones and sets an internal ovf flag.
  - On fall: latch ns=cnt and go to DIV. Falling-edge-to-rising-edge spacing does not affect ns.
- DIV: restoring shift-subtract, one quotient bit per cycle, NUM_W cycles.
  - Numerator = CLK_FS_FREQ*GATE_CYCLES, a NUM_W-bit constant.
  - Divisor = ns zero-extended to NUM_W.
- DONE (exactly 1 cycle):
  - freq <= quotient; if quotient > 2^FREQ_W-1, freq <= all-ones.
  - err <= ovf | quotient_overflow.
  - freq_valid=1. Next state IDLE.
- Latency: freq_valid rises NUM_W+1 cycles after the cycle in which fall is detected (65 cycles at defaults).
- Gate edges while in DIV/DONE are ignored; that gate period is skipped. A rise sampled in the same cycle as DONE→IDLE is also ignored. Measurement restarts on the next rise seen in IDLE.
- ns=0 cannot occur: cnt starts at 1.
- Counter saturation: ns=all-ones is divided normally; err=1 flags the result as invalid.
- Reset mid-COUNT/DIV: immediate return to reset values. The partial result is discarded; freq returns to 0.
- Async-reset flops only; no latches. All arithmetic is unsigned.

Optional Feature:
Macro FX_CALC_ROUND_EN.
- Defined: the numerator becomes CLK_FS_FREQ*GATE_CYCLES + (ns>>1), computed once on entering DIV, which gives round-to-nearest. The NUM_W+1-bit sum must not overflow (guaranteed at defaults).
- Undefined: quotient is truncated (floor).
- Latency is identical either way.

Decomposition:
- Shared package cymometer_pkg:
  - state enum (IDLE, COUNT, DIV, DONE)
  - default constants CLK_FS_FREQ_DEF, GATE_CYCLES_DEF
  - helper function for the numerator constant
- The gate generator also imports GATE_CYCLES_DEF from this package, so both blocks share one value.
- One sub-module: seq_divider (start/done handshake, parameter W). Inputs: num, den. Outputs: quo, busy, done. Exactly W cycles from start to done. fx_calc instantiates it with W=NUM_W.

Test Plan:
- Reset, then gate_fs high 250 cycles → one freq_valid, freq=1_000_000, err=0, strobe 65 cycles after fall detection; freq holds afterwards.
- gate_fs high 7 cycles → freq=35_714_285 without macro, 35_714_286 with FX_CALC_ROUND_EN; gate_fs high 1 cycle → freq=250_000_000.
- Back-to-back gates: second rise arrives 10 cycles after first fall → second gate ignored, exactly one freq_valid; third gate measured normally.
- CNT_W=8, gate_fs high 300 cycles → cnt saturates at 255, freq_valid with err=1, freq=250e6/255 truncated=980_392.
- FREQ_W=16, gate_fs high 250 cycles → freq=16'hFFFF, err=1.
- rst_n pulsed low mid-DIV → freq=0, busy=0, no freq_valid; next 500-cycle gate → freq=500_000.
